// File: rtl/ob_mk_qdeque_if.sv
// ----------------------------------------------------------------------------
// ob_mk_qdeque_if -- command bus of the quantity deque.
//   cmd_vld : command strobe, one command per cycle
//   cmd_op  : 0 NOP, 1 PushFront, 2 PopFront, 3 PushBack, 4 PopBack,
//             5 ConsumeHead, 6 Clear, 7 reserved
//   cmd_key : key of a pushed entry
//   cmd_qty : quantity of a pushed entry, or amount to consume from the head
// master drives the command, slave (the deque) receives it.
// ----------------------------------------------------------------------------
interface ob_mk_qdeque_if #(
   parameter int KEY_W = 32,
   parameter int QTY_W = 10
);
   logic             cmd_vld;
   logic [2:0]       cmd_op;
   logic [KEY_W-1:0] cmd_key;
   logic [QTY_W-1:0] cmd_qty;

   modport master (output cmd_vld, output cmd_op, output cmd_key, output cmd_qty);
   modport slave  (input  cmd_vld, input  cmd_op, input  cmd_key, input  cmd_qty);
endinterface

// File: rtl/ob_mk_qdeque.sv
// ----------------------------------------------------------------------------
// ob_mk_qdeque -- N-deep double-ended queue of {key, qty} entries with a
// running total of resident quantity and in-place partial consumption of the
// head entry.
//   clk, rst        : clock, asynchronous active-high reset
//   cmd             : command bus (slave side of ob_mk_qdeque_if)
//   head_*_r        : front entry (valid/key/qty), zero when invalid
//   tail_*_r        : back entry (valid/key/qty), zero when invalid
//   empty_w, full_w : combinational occupancy flags
//   count_r         : number of resident entries
//   quantity_r      : sum of resident quantities
//   err_r/err_code_r: one-cycle reject pulse (1 overflow, 2 underflow,
//                     3 bad quantity or illegal op)
// All registered outputs reflect a command one clock after it is presented.
// ----------------------------------------------------------------------------
module ob_mk_qdeque #(
   parameter int N     = 8,
   parameter int KEY_W = 32,
   parameter int QTY_W = 10,
   parameter int ACC_W = QTY_W + $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   ob_mk_qdeque_if.slave         cmd,
   output logic                  head_vld_r,
   output logic [KEY_W-1:0]      head_key_r,
   output logic [QTY_W-1:0]      head_qty_r,
   output logic                  tail_vld_r,
   output logic [KEY_W-1:0]      tail_key_r,
   output logic [QTY_W-1:0]      tail_qty_r,
   output logic                  empty_w,
   output logic                  full_w,
   output logic [$clog2(N):0]    count_r,
   output logic [ACC_W-1:0]      quantity_r,
   output logic                  err_r,
   output logic [1:0]            err_code_r
);
   localparam int PW = $clog2(N);
   localparam int CW = PW + 1;

   logic [KEY_W-1:0] key_mem [N];
   logic [QTY_W-1:0] qty_mem [N];

   // head_ptr_r addresses the front entry, tail_ptr_r the back entry
   logic [PW-1:0]    head_ptr_r, tail_ptr_r, head_ptr_s, tail_ptr_s;
   logic [PW-1:0]    head_nxt_ptr_s, tail_prv_ptr_s;
   logic [CW-1:0]    count_s;
   logic [ACC_W-1:0] quantity_s;
   logic             head_vld_s, tail_vld_s, err_s;
   logic [KEY_W-1:0] head_key_s, tail_key_s;
   logic [QTY_W-1:0] head_qty_s, tail_qty_s, consume_rem_s;
   logic [1:0]       err_code_s;
   logic             do_push_front_s, do_push_back_s, do_pop_front_s;
   logic             do_pop_back_s, do_consume_s, do_clear_s;
   logic             mem_we_s;
   logic [PW-1:0]    mem_waddr_s;
   logic [KEY_W-1:0] mem_wkey_s;
   logic [QTY_W-1:0] mem_wqty_s;

   assign empty_w        = (count_r == CW'(0));
   assign full_w         = (count_r == CW'(N));
   assign head_nxt_ptr_s = head_ptr_r + PW'(1);
   assign tail_prv_ptr_s = tail_ptr_r - PW'(1);
   assign consume_rem_s  = head_qty_r - cmd.cmd_qty;

   // Command decode: legality check and selection of one action
   always_comb begin
      do_push_front_s = 1'b0;
      do_push_back_s  = 1'b0;
      do_pop_front_s  = 1'b0;
      do_pop_back_s   = 1'b0;
      do_consume_s    = 1'b0;
      do_clear_s      = 1'b0;
      err_s           = 1'b0;
      err_code_s      = 2'd0;
      if (cmd.cmd_vld) begin
         case (cmd.cmd_op)
            3'd0: begin
               err_s = 1'b0;
            end
            3'd1, 3'd3: begin
               if (full_w) begin
                  err_s = 1'b1; err_code_s = 2'd1;
               end else if (cmd.cmd_qty == QTY_W'(0)) begin
                  err_s = 1'b1; err_code_s = 2'd3;
               end else if (cmd.cmd_op == 3'd1) begin
                  do_push_front_s = 1'b1;
               end else begin
                  do_push_back_s = 1'b1;
               end
            end
            3'd2, 3'd4: begin
               if (empty_w) begin
                  err_s = 1'b1; err_code_s = 2'd2;
               end else if (cmd.cmd_op == 3'd2) begin
                  do_pop_front_s = 1'b1;
               end else begin
                  do_pop_back_s = 1'b1;
               end
            end
            3'd5: begin
               if (empty_w) begin
                  err_s = 1'b1; err_code_s = 2'd2;
               end else if ((cmd.cmd_qty == QTY_W'(0)) || (cmd.cmd_qty > head_qty_r)) begin
                  err_s = 1'b1; err_code_s = 2'd3;
               end else if (consume_rem_s == QTY_W'(0)) begin
                  // fully consumed head behaves exactly like PopFront
                  do_pop_front_s = 1'b1;
               end else begin
                  do_consume_s = 1'b1;
               end
            end
            3'd6: begin
               do_clear_s = 1'b1;
            end
            default: begin
               err_s = 1'b1; err_code_s = 2'd3;
            end
         endcase
      end else begin
         err_s = 1'b0;
      end
   end

   // Next-state computation for pointers, occupancy, totals and end entries
   always_comb begin
      head_ptr_s  = head_ptr_r;
      tail_ptr_s  = tail_ptr_r;
      count_s     = count_r;
      quantity_s  = quantity_r;
      head_vld_s  = head_vld_r;
      head_key_s  = head_key_r;
      head_qty_s  = head_qty_r;
      tail_vld_s  = tail_vld_r;
      tail_key_s  = tail_key_r;
      tail_qty_s  = tail_qty_r;
      mem_we_s    = 1'b0;
      mem_waddr_s = head_ptr_r;
      mem_wkey_s  = cmd.cmd_key;
      mem_wqty_s  = cmd.cmd_qty;
      if (do_push_front_s || do_push_back_s) begin
         mem_we_s   = 1'b1;
         count_s    = count_r + CW'(1);
         quantity_s = quantity_r + ACC_W'(cmd.cmd_qty);
         if (empty_w) begin
            // first entry: both ends point at the same slot
            tail_ptr_s = head_ptr_r;
            head_vld_s = 1'b1; head_key_s = cmd.cmd_key; head_qty_s = cmd.cmd_qty;
            tail_vld_s = 1'b1; tail_key_s = cmd.cmd_key; tail_qty_s = cmd.cmd_qty;
         end else if (do_push_front_s) begin
            head_ptr_s  = head_ptr_r - PW'(1);
            mem_waddr_s = head_ptr_r - PW'(1);
            head_key_s  = cmd.cmd_key; head_qty_s = cmd.cmd_qty;
         end else begin
            tail_ptr_s  = tail_ptr_r + PW'(1);
            mem_waddr_s = tail_ptr_r + PW'(1);
            tail_key_s  = cmd.cmd_key; tail_qty_s = cmd.cmd_qty;
         end
      end else if (do_pop_front_s || do_pop_back_s) begin
         count_s    = count_r - CW'(1);
         quantity_s = quantity_r - ACC_W'(do_pop_front_s ? head_qty_r : tail_qty_r);
         if (count_r == CW'(1)) begin
            head_vld_s = 1'b0; head_key_s = KEY_W'(0); head_qty_s = QTY_W'(0);
            tail_vld_s = 1'b0; tail_key_s = KEY_W'(0); tail_qty_s = QTY_W'(0);
         end else if (do_pop_front_s) begin
            head_ptr_s = head_nxt_ptr_s;
            head_key_s = key_mem[head_nxt_ptr_s];
            head_qty_s = qty_mem[head_nxt_ptr_s];
         end else begin
            tail_ptr_s = tail_prv_ptr_s;
            tail_key_s = key_mem[tail_prv_ptr_s];
            tail_qty_s = qty_mem[tail_prv_ptr_s];
         end
      end else if (do_consume_s) begin
         // storage keeps the reduced qty so a later pop exposes it correctly
         mem_we_s   = 1'b1;
         mem_wkey_s = head_key_r;
         mem_wqty_s = consume_rem_s;
         quantity_s = quantity_r - ACC_W'(cmd.cmd_qty);
         head_qty_s = consume_rem_s;
         if (count_r == CW'(1)) begin
            tail_qty_s = consume_rem_s;
         end else begin
            tail_qty_s = tail_qty_r;
         end
      end else if (do_clear_s) begin
         head_ptr_s = PW'(0);
         tail_ptr_s = PW'(0);
         count_s    = CW'(0);
         quantity_s = ACC_W'(0);
         head_vld_s = 1'b0; head_key_s = KEY_W'(0); head_qty_s = QTY_W'(0);
         tail_vld_s = 1'b0; tail_key_s = KEY_W'(0); tail_qty_s = QTY_W'(0);
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_ptr_r <= PW'(0);
         tail_ptr_r <= PW'(0);
         count_r    <= CW'(0);
         quantity_r <= ACC_W'(0);
         head_vld_r <= 1'b0;
         head_key_r <= KEY_W'(0);
         head_qty_r <= QTY_W'(0);
         tail_vld_r <= 1'b0;
         tail_key_r <= KEY_W'(0);
         tail_qty_r <= QTY_W'(0);
         err_r      <= 1'b0;
         err_code_r <= 2'd0;
      end else begin
         head_ptr_r <= head_ptr_s;
         tail_ptr_r <= tail_ptr_s;
         count_r    <= count_s;
         quantity_r <= quantity_s;
         head_vld_r <= head_vld_s;
         head_key_r <= head_key_s;
         head_qty_r <= head_qty_s;
         tail_vld_r <= tail_vld_s;
         tail_key_r <= tail_key_s;
         tail_qty_r <= tail_qty_s;
         err_r      <= err_s;
         err_code_r <= err_code_s;
      end
   end

   // Entry storage, intentionally not reset
   always_ff @(posedge clk) begin
      if (mem_we_s && !rst) begin
         key_mem[mem_waddr_s] <= mem_wkey_s;
         qty_mem[mem_waddr_s] <= mem_wqty_s;
      end
   end
endmodule

// File: doc/ob_mk_qdeque.md
OB_MK_QDEQUE -- requirements
Module: ob_mk_qdeque

Interface
REQ-001 SHALL have parameter N, default 8, deque depth; power of two, >= 2.
REQ-002 SHALL have parameter KEY_W, default 32, entry key width.
REQ-003 SHALL have parameter QTY_W, default 10, per-entry quantity width.
REQ-004 SHALL have parameter ACC_W, default QTY_W+$clog2(N), accumulated-quantity width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 cmd_vld  in  1  command strobe, one command per cycle.
REQ-009 cmd_op  in  3  0 NOP, 1 PushFront, 2 PopFront, 3 PushBack, 4 PopBack, 5 ConsumeHead, 6 Clear, 7 reserved.
REQ-010 cmd_key  in  KEY_W  push key.
REQ-011 cmd_qty  in  QTY_W  push quantity or consume amount.
REQ-012 head_vld_r / head_key_r / head_qty_r  out  1/KEY_W/QTY_W  front entry.
REQ-013 tail_vld_r / tail_key_r / tail_qty_r  out  1/KEY_W/QTY_W  back entry.
REQ-014 empty_w / full_w  out  1/1  combinational, count_r==0 / count_r==N.
REQ-015 count_r  out  $clog2(N)+1  occupancy.
REQ-016 quantity_r  out  ACC_W  sum of quantities of all resident entries.
REQ-017 err_r / err_code_r  out  1/2  one-cycle reject pulse; code 1 overflow, 2 underflow, 3 bad qty/illegal op.

Function
REQ-018 SHALL store entries in an N-deep circular buffer with head/tail pointers wrapping modulo N.
REQ-019 Accepted command SHALL update all registered outputs at the next rising edge (latency 1); back-to-back commands every cycle.
REQ-020 PushFront/PushBack SHALL insert {cmd_key,cmd_qty} at front/back; count +1; quantity_r += cmd_qty.
REQ-021 PopFront/PopBack SHALL remove front/back entry; count -1; quantity_r -= removed qty.
REQ-022 ConsumeHead SHALL subtract cmd_qty from head qty and from quantity_r; if result is 0, head entry popped (count -1).
REQ-023 Clear SHALL set count 0, quantity_r 0, head/tail invalid.
REQ-024 Push when full -> reject, code 1; Pop/ConsumeHead when empty -> reject, code 2.
REQ-025 Push with cmd_qty==0, ConsumeHead with cmd_qty==0 or > head qty, op 7 -> reject, code 3.
REQ-026 Rejected command SHALL leave all state unchanged except err_r=1, err_code_r set for one cycle; otherwise err_r=0, err_code_r=0.
REQ-027 cmd_vld=0 or NOP SHALL change no state.
REQ-028 count==1: head and tail SHALL reference same entry; PopFront and PopBack equivalent; ConsumeHead updates head_qty_r and tail_qty_r identically.
REQ-029 Invalid head/tail SHALL drive key and qty outputs to 0.
REQ-030 quantity_r SHALL never wrap: ACC_W holds N*(2^QTY_W-1).
REQ-031 Push onto empty SHALL set head and tail to the new entry.

Reset
REQ-032 rst assertion SHALL immediately clear pointers, count_r, quantity_r, head/tail valid, key, qty, err_r, err_code_r to 0; storage array not reset.
REQ-033 Command presented during reset SHALL be ignored; first command accepted on first edge after deassertion.

Verification
REQ-034 Reset, PushBack(k=1,q=5), PushBack(k=2,q=7) -> count 2, quantity 12, head k1/q5, tail k2/q7.
REQ-035 From 034: ConsumeHead(3) -> head q2, quantity 9; ConsumeHead(2) -> head k2/q7, count 1, quantity 7; ConsumeHead(8) -> err code 3, no change.
REQ-036 N=8: 8 PushFront (q=1..8), 9th push -> err code 1, full_w=1, quantity 36; 8 PopBack then PopBack -> err code 2, empty_w=1, quantity 0.
REQ-037 Alternate PushBack/PopFront 3N times -> pointer wrap, count never above 1, head==tail each push cycle.
REQ-038 3 entries, Clear -> count 0, quantity 0, head_vld_r=0; then PushFront(k=9,q=4) -> head=tail=k9/q4.
REQ-039 Assert rst mid-stream with count 5 -> all outputs 0 same cycle; op 7 after reset -> err code 3.
